// File: rtl/isa_pkg.sv
// Shared ISA constants and hazard-controller state encoding.
// Used by the decode logic, the controller FSM and the bench.
package isa_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: instruction words in,
// latch enables / bubble selects / multdiv handshake out.
interface hazard_ctrl_if;
  logic [31:0] ir_fd;
  logic [31:0] ir_dx;
  logic        branch_taken;
  logic        en_pc;
  logic        en_fd;
  logic        en_dx;
  logic        en_xm;
  logic        en_mw;
  logic        fd_bubble;
  logic        dx_bubble;
  logic        xm_bubble;
  logic        md_start;
  logic        md_busy;
  logic [15:0] stall_cycles;

  modport master (
    output ir_fd, ir_dx, branch_taken,
    input  en_pc, en_fd, en_dx, en_xm, en_mw,
    input  fd_bubble, dx_bubble, xm_bubble,
    input  md_start, md_busy, stall_cycles
  );

  modport slave (
    input  ir_fd, ir_dx, branch_taken,
    output en_pc, en_fd, en_dx, en_xm, en_mw,
    output fd_bubble, dx_bubble, xm_bubble,
    output md_start, md_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_decode.sv
// Combinational field extraction: load-use detection between D/X and F/D,
// and mul/div recognition on the instruction in D/X.
module hazard_decode
  import isa_pkg::*;
(
  input  logic [31:0] ir_fd,
  input  logic [31:0] ir_dx,
  output logic        load_use,
  output logic        mdop
);

  logic [4:0] fd_op_s, fd_rd_s, fd_rs_s, fd_rt_s;
  logic [4:0] dx_op_s, dx_rd_s, dx_alu_s;
  logic       use_rs_s, use_rt_s, use_rd_s;
  logic       unused_bits_s;

  assign fd_op_s  = ir_fd[31:27];
  assign fd_rd_s  = ir_fd[26:22];
  assign fd_rs_s  = ir_fd[21:17];
  assign fd_rt_s  = ir_fd[16:12];
  assign dx_op_s  = ir_dx[31:27];
  assign dx_rd_s  = ir_dx[26:22];
  assign dx_alu_s = ir_dx[6:2];
  assign unused_bits_s = ^{ir_fd[11:0], ir_dx[21:7], ir_dx[1:0]};

  // Which register fields of the F/D instruction are actually read
  always_comb begin
    use_rs_s = 1'b0;
    use_rt_s = 1'b0;
    use_rd_s = 1'b0;
    case (fd_op_s)
      OP_RTYPE: begin
        use_rs_s = 1'b1;
        use_rt_s = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_rs_s = 1'b1;
      end
      OP_SW, OP_BNE, OP_BLT: begin
        use_rs_s = 1'b1;
        use_rd_s = 1'b1;
      end
      OP_JR: begin
        use_rd_s = 1'b1;
      end
      default: begin
        use_rs_s = 1'b0;
        use_rt_s = 1'b0;
        use_rd_s = 1'b0;
      end
    endcase
  end

  // A load into $0 never creates a dependency
  assign load_use = (dx_op_s == OP_LW) && (dx_rd_s != 5'd0) &&
                    ((use_rs_s && (fd_rs_s == dx_rd_s)) ||
                     (use_rt_s && (fd_rt_s == dx_rd_s)) ||
                     (use_rd_s && (fd_rd_s == dx_rd_s)));

  assign mdop = (dx_op_s == OP_RTYPE) &&
                ((dx_alu_s == ALU_MUL) || (dx_alu_s == ALU_DIV));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multdiv stall FSM, branch flush and load-use
// interlock, plus a saturating count of PC-stall cycles.
module hazard_ctrl
  import isa_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
)(
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  md_state_e   state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [15:0] stall_r;
  logic        load_use_s, mdop_s;
  logic        en_pc_s, en_fd_s, en_dx_s;
  logic        fd_bubble_s, dx_bubble_s, xm_bubble_s;
  logic        md_start_s, md_busy_s;

  hazard_decode u_decode (
    .ir_fd    (hz.ir_fd),
    .ir_dx    (hz.ir_dx),
    .load_use (load_use_s),
    .mdop     (mdop_s)
  );

  // FSM state and multdiv cycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state and stall/flush decode; priority mdop > branch > load-use
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    en_pc_s     = 1'b1;
    en_fd_s     = 1'b1;
    en_dx_s     = 1'b1;
    fd_bubble_s = 1'b0;
    dx_bubble_s = 1'b0;
    xm_bubble_s = 1'b0;
    md_start_s  = 1'b0;
    md_busy_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mdop_s) begin
          md_start_s  = 1'b1;
          en_pc_s     = 1'b0;
          en_fd_s     = 1'b0;
          en_dx_s     = 1'b0;
          xm_bubble_s = 1'b1;
          cnt_s       = MD_LOAD;
          state_s     = ST_BUSY;
        end else if (hz.branch_taken) begin
          fd_bubble_s = 1'b1;
          dx_bubble_s = 1'b1;
        end else if (load_use_s) begin
          en_pc_s     = 1'b0;
          en_fd_s     = 1'b0;
          dx_bubble_s = 1'b1;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_BUSY: begin
        en_pc_s     = 1'b0;
        en_fd_s     = 1'b0;
        en_dx_s     = 1'b0;
        xm_bubble_s = 1'b1;
        md_busy_s   = 1'b1;
        if (cnt_r == 8'd0) begin
          state_s = ST_DONE;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Saturating count of cycles in which the PC is frozen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_r <= 16'd0;
    end else if (!en_pc_s && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign hz.en_pc        = en_pc_s;
  assign hz.en_fd        = en_fd_s;
  assign hz.en_dx        = en_dx_s;
  assign hz.en_xm        = 1'b1;
  assign hz.en_mw        = 1'b1;
  assign hz.fd_bubble    = fd_bubble_s;
  assign hz.dx_bubble    = dx_bubble_s;
  assign hz.xm_bubble    = xm_bubble_s;
  // No start pulse may escape while reset is held
  assign hz.md_start     = md_start_s & reset;
  assign hz.md_busy      = md_busy_s;
  assign hz.stall_cycles = stall_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected control
// words; a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
  import isa_pkg::*;

  // {en_pc,en_fd,en_dx,en_xm,en_mw, fd_b,dx_b,xm_b, md_start,md_busy}
  localparam logic [9:0] C_NORM   = 10'b11111_000_00;
  localparam logic [9:0] C_LU     = 10'b00111_010_00;
  localparam logic [9:0] C_BR     = 10'b11111_110_00;
  localparam logic [9:0] C_START  = 10'b00011_001_10;
  localparam logic [9:0] C_BUSY   = 10'b00011_001_01;
  localparam logic [9:0] C_RST_MD = 10'b00011_001_00;

  localparam logic [31:0] I_ADD   = 32'h0106_5000; // add $4,$3,$5
  localparam logic [31:0] I_LW3   = 32'h40C0_0000;
  localparam logic [31:0] I_LW0   = 32'h4000_0000;
  localparam logic [31:0] I_LW4   = 32'h4100_0000;
  localparam logic [31:0] I_LW5   = 32'h4140_0000;
  localparam logic [31:0] I_SW4   = 32'h3900_0000; // rd=$4 read as source
  localparam logic [31:0] I_JR4   = 32'h2100_0000; // rd=$4 read as source
  localparam logic [31:0] I_JRRS4 = 32'h2008_0000; // only rs=$4, not read
  localparam logic [31:0] I_SUB   = 32'h0000_0014; // R-type aluop 00101
  localparam logic [31:0] I_MUL   = 32'h0044_3018;
  localparam logic [31:0] I_DIV   = 32'h0000_001C;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [15:0] stall;
  } exp_t;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  exp_t  mon_exp;
  exp_t  mon_got;
  string mon_name;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz_if)
  );

  always #5 clock = ~clock;

  // Monitor: one expected response per pushed vector, sampled mid-cycle
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = {hz_if.en_pc, hz_if.en_fd, hz_if.en_dx, hz_if.en_xm, hz_if.en_mw,
                  hz_if.fd_bubble, hz_if.dx_bubble, hz_if.xm_bubble,
                  hz_if.md_start, hz_if.md_busy, hz_if.stall_cycles};
      checks++;
      if (mon_got !== mon_exp) begin
        failures++;
        $display("FAIL %s: got ctrl=%b stall=%h, expected ctrl=%b stall=%h",
                 mon_name, mon_got.ctrl, mon_got.stall, mon_exp.ctrl, mon_exp.stall);
      end
    end
  end

  task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                      input logic rst, input logic [9:0] ectrl, input logic [15:0] estall,
                      input string nm);
    @(posedge clock);
    #1;
    hz_if.ir_fd        = fd;
    hz_if.ir_dx        = dx;
    hz_if.branch_taken = br;
    reset              = rst;
    exp_q.push_back(exp_t'({ectrl, estall}));
    name_q.push_back(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    hz_if.ir_fd        = NOP;
    hz_if.ir_dx        = I_MUL;
    hz_if.branch_taken = 1'b0;

    step(NOP,     I_MUL,   1'b0, 1'b0, C_RST_MD, 16'd0, "reset_decode");
    step(I_ADD,   NOP,     1'b0, 1'b1, C_NORM,   16'd0, "normal");
    step(I_ADD,   I_LW3,   1'b0, 1'b1, C_LU,     16'd0, "lu_rs");
    step(I_ADD,   NOP,     1'b0, 1'b1, C_NORM,   16'd1, "lu_released");
    step(I_ADD,   I_LW0,   1'b0, 1'b1, C_NORM,   16'd1, "lw_r0");
    step(I_ADD,   I_LW5,   1'b0, 1'b1, C_LU,     16'd1, "lu_rt");
    step(I_ADD,   I_LW4,   1'b0, 1'b1, C_NORM,   16'd2, "rtype_rd_dest");
    step(I_SW4,   I_LW4,   1'b0, 1'b1, C_LU,     16'd2, "lu_sw_rd");
    step(I_JR4,   I_LW4,   1'b0, 1'b1, C_LU,     16'd3, "lu_jr_rd");
    step(I_JRRS4, I_LW4,   1'b0, 1'b1, C_NORM,   16'd4, "jr_rs_unused");
    step(I_ADD,   I_LW3,   1'b1, 1'b1, C_BR,     16'd4, "branch_over_lu");
    step(NOP,     I_SUB,   1'b0, 1'b1, C_NORM,   16'd4, "rtype_not_md");

    step(NOP,     I_MUL,   1'b0, 1'b1, C_START,  16'd4, "mul_start");
    step(NOP,     I_MUL,   1'b1, 1'b1, C_BUSY,   16'd5, "mul_busy1");
    step(NOP,     I_MUL,   1'b0, 1'b1, C_BUSY,   16'd6, "mul_busy2");
    step(NOP,     I_MUL,   1'b1, 1'b1, C_BUSY,   16'd7, "mul_busy3");
    step(NOP,     I_MUL,   1'b0, 1'b1, C_BUSY,   16'd8, "mul_busy4");
    step(NOP,     I_MUL,   1'b1, 1'b1, C_NORM,   16'd9, "mul_done");
    step(NOP,     NOP,     1'b0, 1'b1, C_NORM,   16'd9, "after_done");

    step(NOP,     I_DIV,   1'b0, 1'b1, C_START,  16'd9,  "div_start");
    step(NOP,     I_DIV,   1'b0, 1'b1, C_BUSY,   16'd10, "div_busy1");
    step(NOP,     I_DIV,   1'b0, 1'b1, C_BUSY,   16'd11, "div_busy2");
    step(NOP,     I_DIV,   1'b0, 1'b0, C_RST_MD, 16'd0,  "div_abort_reset");
    step(NOP,     NOP,     1'b0, 1'b1, C_NORM,   16'd0,  "abort_release");
    step(NOP,     NOP,     1'b0, 1'b1, C_NORM,   16'd0,  "abort_no_done");

    // Hold a load-use stall long enough to run past 16 bits
    @(posedge clock);
    #1;
    hz_if.ir_fd        = I_ADD;
    hz_if.ir_dx        = I_LW3;
    hz_if.branch_taken = 1'b0;
    repeat (70000) @(posedge clock);

    step(I_ADD,   NOP,     1'b0, 1'b1, C_NORM,   16'hFFFF, "stall_saturated");
    step(I_ADD,   I_LW3,   1'b0, 1'b1, C_LU,     16'hFFFF, "stall_sat_lu");
    step(I_ADD,   NOP,     1'b0, 1'b1, C_NORM,   16'hFFFF, "stall_sat_hold");

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32: number of BUSY cycles for one mul/div operation, legal range 2..255.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset is asserted while low.
REQ-004 ir_fd  in  32  instruction held in the F/D latch.
REQ-005 ir_dx  in  32  instruction at the D/X latch output (ir_out).
REQ-006 branch_taken  in  1  X stage resolves a taken branch or jump this cycle.
REQ-007 en_pc, en_fd, en_dx, en_xm, en_mw  out  1 each  write enables for the PC and the four pipeline latches.
REQ-008 fd_bubble, dx_bubble, xm_bubble  out  1 each  the named latch loads nop (32'h0) instead of its data input.
REQ-009 md_start  out  1  one-cycle start pulse to the multdiv unit.
REQ-010 md_busy  out  1  high while the FSM is in BUSY.
REQ-011 stall_cycles  out  16  count of cycles with en_pc low, saturating.

Function
REQ-012 Decode fields are opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2]; R-type is opcode 00000 and lw is opcode 01000.
REQ-013 Sources of ir_fd: rs for opcodes 00000/00101/00111/01000/00010/00110; rt for R-type; rd for 00111/00010/00110/00100.
REQ-014 Load-use hazard = ir_dx is lw, its rd != 0, and that rd equals any source of ir_fd.
REQ-015 mdop = ir_dx is R-type with aluop 00110 (mul) or 00111 (div).
REQ-016 FSM states are IDLE, BUSY and DONE; reset state is IDLE.
REQ-017 IDLE with mdop: md_start=1, en_pc=en_fd=en_dx=0, xm_bubble=1, counter loads MD_CYCLES-1, next state BUSY.
REQ-018 BUSY: same enables and xm_bubble as REQ-017, md_start=0, counter decrements each cycle; when the counter is 0, next state is DONE.
REQ-019 DONE: all enables 1 and all bubbles 0, so the result enters X/M; next state is IDLE; no retrigger occurs this cycle.
REQ-020 In IDLE without mdop, branch_taken=1: all enables 1, fd_bubble=1, dx_bubble=1.
REQ-021 In IDLE without mdop or branch, load-use: en_pc=en_fd=0, dx_bubble=1, other enables 1.
REQ-022 Priority: mdop > branch_taken > load-use > normal (all enables 1, bubbles 0).
REQ-023 branch_taken is ignored in BUSY and DONE.
REQ-024 en_xm and en_mw are 1 in every state; a stall freezes only upstream stages.
REQ-025 stall_cycles increments on every cycle with en_pc=0 and holds at 16'hFFFF.
REQ-026 All outputs are combinational from the FSM state and inputs, except stall_cycles, which is registered.

Reset
REQ-027 While reset is low: state=IDLE, counter=0, stall_cycles=0, md_start=0, md_busy=0; enables and bubbles follow the IDLE decode.
REQ-028 Reset asserted in BUSY aborts the operation immediately, with no DONE cycle and no md_start on release.

Structure
REQ-029 Opcode and aluop constants, the FSM state encoding and the nop value live in a shared package, isa_pkg.
REQ-030 One sub-module, hazard_decode: purely combinational source, lw and mdop extraction from ir_fd/ir_dx.

Verification
REQ-031 ir_dx=32'h40C00000 (lw $3), ir_fd=32'h01065000 (add $4,$3,$5) -> en_pc=0, en_fd=0, dx_bubble=1 for 1 cycle; stall_cycles=1.
REQ-032 ir_dx=32'h40000000 (lw $0), same ir_fd -> no stall, all enables 1.
REQ-033 MD_CYCLES=4, ir_dx=32'h00443018 (mul) -> md_start for 1 cycle, md_busy for 4 cycles, DONE on cycle 6, en_pc low for 5 cycles, stall_cycles=5.
REQ-034 branch_taken=1 together with a load-use condition -> fd_bubble=1, dx_bubble=1, en_pc=1, no stall.
REQ-035 reset pulsed low during BUSY -> md_busy=0 immediately, state IDLE, stall_cycles=0, no DONE cycle.
REQ-036 Force 70000 consecutive stall cycles -> stall_cycles saturates at 16'hFFFF.
